// File: rtl/icache_line.sv
// icache_line: direct-mapped instruction cache with multi-word lines and a burst line refill.
// Optional feature macro: ICACHE_FLUSH_EN adds a flush port that invalidates every line.
module icache_line #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] pc_from_if,
  output logic        inst_enable,
  output logic [31:0] inst_to_if,
  output logic        addr_enable,
  output logic [31:0] addr_to_mem,
  input  logic        mem_valid,
  input  logic [31:0] inst_from_mem,
`ifdef ICACHE_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy
);

  localparam int LINES  = 1 << INDEX_BITS;
  localparam int WPL    = 1 << OFFSET_BITS;
  localparam int LO     = OFFSET_BITS + 2;
  localparam int IDX_HI = INDEX_BITS + LO - 1;
  localparam int TAG_LO = IDX_HI + 1;
  localparam int TAG_HI = TAG_LO + TAG_BITS - 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_n;

  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic [31:0]            data_mem [LINES*WPL];
  logic [OFFSET_BITS-1:0] k, k_n, k_inc;

  logic                   inst_enable_n, addr_enable_n;
  logic [31:0]            inst_to_if_n, addr_to_mem_n;
  logic                   fill_we, line_done, clear_all, flush_req;

  logic [INDEX_BITS-1:0]  pc_index, fill_index;
  logic [OFFSET_BITS-1:0] pc_word;
  logic [TAG_BITS-1:0]    pc_tag, fill_tag;
  logic                   hit;
  logic                   unused_pc_bits;

`ifdef ICACHE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign pc_word    = pc_from_if[LO-1:2];
  assign pc_index   = pc_from_if[IDX_HI:LO];
  assign pc_tag     = pc_from_if[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^pc_from_if[1:0];

  // The line base stays latched in the upper bits of addr_to_mem for the whole burst.
  assign fill_index = addr_to_mem[IDX_HI:LO];
  assign fill_tag   = addr_to_mem[TAG_HI:TAG_LO];
  assign k_inc      = k + OFFSET_BITS'(1);

  assign hit  = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign busy = (state == REFILL);

  always_comb begin
    state_n       = state;
    k_n           = k;
    inst_enable_n = 1'b0;
    inst_to_if_n  = inst_to_if;
    addr_enable_n = addr_enable;
    addr_to_mem_n = addr_to_mem;
    fill_we       = 1'b0;
    line_done     = 1'b0;
    clear_all     = 1'b0;
    if (rdy) begin
      if (flush_req) begin
        clear_all     = 1'b1;
        state_n       = IDLE;
        k_n           = '0;
        addr_enable_n = 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (if_valid && hit) begin
              inst_enable_n = 1'b1;
              inst_to_if_n  = data_mem[{pc_index, pc_word}];
              addr_enable_n = 1'b0;
            end else if (if_valid) begin
              state_n       = REFILL;
              k_n           = '0;
              addr_enable_n = 1'b1;
              addr_to_mem_n = {pc_from_if[31:LO], {LO{1'b0}}};
            end else begin
              addr_enable_n = 1'b0;
            end
          end
          REFILL: begin
            if (mem_valid) begin
              fill_we = 1'b1;
              if (&k) begin
                line_done     = 1'b1;
                state_n       = IDLE;
                k_n           = '0;
                addr_enable_n = 1'b0;
              end else begin
                k_n           = k_inc;
                addr_to_mem_n = {addr_to_mem[31:LO], k_inc, 2'b00};
              end
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      inst_enable <= 1'b0;
      inst_to_if  <= '0;
      addr_enable <= 1'b0;
      addr_to_mem <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      inst_enable <= inst_enable_n;
      inst_to_if  <= inst_to_if_n;
      addr_enable <= addr_enable_n;
      addr_to_mem <= addr_to_mem_n;
    end
  end

  // A line only becomes valid once its final word has landed.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      valid <= '0;
    end else if (line_done) begin
      valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      data_mem[{fill_index, k}] <= inst_from_mem;
    end
    if (line_done && !rst) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

endmodule

// File: doc/icache_line.md
Name: icache_line

Overview:
Parametrised direct-mapped instruction cache with multi-word lines. It sits between the instruction-fetch unit and the memory controller's instruction port. On a miss, it refills a whole line through a burst of single-word requests. Compared with the single-word cache, it adds configurable geometry, a latched refill address, refills that run to completion even if the request is withdrawn, and optional flush.

Parameters:
- INDEX_BITS, 6, log2 of the number of lines.
- OFFSET_BITS, 2, log2 of the words per line. Words per line WPL = 2^OFFSET_BITS; OFFSET_BITS >= 1.
- TAG_BITS, 8, stored tag width. PC bits above the tag field are ignored (aliasing permitted).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global ready; low freezes the block.
- if_valid  in  1  fetch request valid.
- pc_from_if  in  32  fetch address; bits [1:0] ignored.
- inst_enable  out  1  registered hit/data-valid strobe to IF.
- inst_to_if  out  32  instruction word.
- addr_enable  out  1  memory word request.
- addr_to_mem  out  32  word address of the request.
- mem_valid  in  1  memory returned the requested word.
- inst_from_mem  in  32  returned word.
- busy  out  1  high while the FSM is in REFILL.
- flush  in  1  invalidate all lines (present only with ICACHE_FLUSH_EN).

Behaviour:
- Address split:
  - word = pc[OFFSET_BITS+1:2]
  - index = pc[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2]
  - tag = next TAG_BITS bits above index.
- Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^INDEX_BITS][WPL] x 32.
- hit = valid[index] && tag[index]==pc tag (combinational).
- Reset values:
  - valid all 0; FSM to IDLE; refill counter 0.
  - inst_enable=0, addr_enable=0, busy=0, inst_to_if=0, addr_to_mem=0.
  - Tag and data contents are don't-care.
- rdy=0: no state, array, counter or address change. inst_enable forced 0 next edge. addr_enable and addr_to_mem hold. mem_valid ignored.
- IDLE state:
  - if_valid && hit: next edge inst_enable=1 and inst_to_if=data[index][word]. This is 1-cycle hit latency, repeated every cycle the request is held.
  - if_valid && !hit: inst_enable=0. Latch refill base = {pc[31:OFFSET_BITS+2], OFFSET_BITS+2 zero bits}; k=0; addr_enable=1; addr_to_mem=base; busy=1; go to REFILL.
  - !if_valid: inst_enable=0, addr_enable=0.
- REFILL state:
  - inst_enable=0 every cycle; no lookups are served.
  - addr_enable stays 1 and addr_to_mem is stable until mem_valid.
  - On mem_valid: write data[base index][k] = inst_from_mem.
    - If k<WPL-1: k<=k+1 and addr_to_mem<=base+4*(k+1) at the same edge.
    - If k==WPL-1: set valid and tag for the base index; addr_enable=0; busy=0; go to IDLE.
  - The refill always completes, even if if_valid drops or the PC changes; the fetched line stays cached.
- mem_valid while in IDLE or while addr_enable=0: ignored.
- After a refill completes, a still-pending request hits in the next IDLE cycle. inst_enable rises 2 edges after the final mem_valid edge.
- Fill of a line overwrites any previous line at that index (conflict eviction).
- rst mid-refill: refill abandoned, line stays invalid, all outputs return to reset values next edge.
- Counter k is OFFSET_BITS wide; the address increment never carries into the index field.

Optional Feature:
ICACHE_FLUSH_EN
- Defined: flush port exists. flush=1 with rdy=1 clears all valid bits at the edge. inst_enable=0 that cycle. If in REFILL, the refill aborts: FSM to IDLE, addr_enable=0, busy=0, line not validated. Flush has priority over the mem_valid completion on the same edge.
- Undefined: no flush port; valid bits clear only on rst.

Test Plan (defaults; line = 16 B):
- Cold miss: if_valid=1, pc=0x100 -> addr_to_mem 0x100, 0x104, 0x108, 0x10C, each advancing after its mem_valid. Return 0xA0..0xA3. Two edges after the last beat, inst_enable=1 and inst_to_if=0xA0.
- Same-line hit: after the fill, pc=0x108 -> inst_enable=1 next edge with 0xA2, and addr_enable stays 0.
- Conflict: pc=0x500 (same index 0x10, tag 1) -> refill of 0x500..0x50C. Then pc=0x100 misses again and refetches.
- Withdrawn request: miss at 0x200, drop if_valid after beat 1 -> remaining beats 0x208, 0x20C still issued. A later pc=0x204 hits without any memory request.
- rdy stall: rdy=0 for 3 cycles mid-refill -> addr_to_mem is unchanged, mem_valid is ignored, and the counter is unchanged. The burst resumes when rdy returns.
- With ICACHE_FLUSH_EN: flush after the 0x100 fill -> pc=0x100 misses. Flush during beat 2 of a refill -> addr_enable=0 next edge and the line is not valid.
